uart_image_loader: RTL and testbench
====================================

UART_IMAGE_LOADER -- requirements
Module: uart_image_loader

Interface
REQ-001 SHALL have parameter N_PIXELS, default 784, meaning pixel bytes per frame.
REQ-002 SHALL have parameter ADDR_W, default 10, meaning image-memory address width (2^ADDR_W >= N_PIXELS).
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, meaning frame header byte.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 50000, meaning max clk cycles between bytes inside a frame.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, meaning synchronous active-high reset.
REQ-007 SHALL have port rx_done_tick, input, 1, meaning one-cycle strobe that rx_byte is valid.
REQ-008 SHALL have port rx_byte, input, 8, meaning received UART byte.
REQ-009 SHALL have ports mem_we (output, 1), mem_addr (output, ADDR_W) and mem_wdata (output, 8), meaning the image-memory write port.
REQ-010 SHALL have port net_start, output, 1, meaning one-cycle pulse that launches inference.
REQ-011 SHALL have port net_done, input, 1, meaning one-cycle pulse that inference finished.
REQ-012 SHALL have port busy, output, 1, meaning high in every state except IDLE.
REQ-013 SHALL have port err, output, 2, meaning a one-cycle error code: 00 none, 01 timeout, 10 checksum, 11 overrun.

Function
REQ-014 SHALL implement states IDLE, LOAD, CHECK, START, RUN.
REQ-015 In IDLE, SHALL discard bytes until rx_done_tick with rx_byte==SYNC_BYTE, then go to LOAD with the pixel counter at 0.
REQ-016 In LOAD, on each rx_done_tick SHALL, in the same cycle, drive mem_we=1, mem_addr=counter, mem_wdata=rx_byte; counter SHALL then increment.
REQ-017 A byte equal to SYNC_BYTE inside LOAD SHALL be treated as pixel data, not as a resync.
REQ-018 After the byte at counter==N_PIXELS-1 is written, SHALL go to CHECK when CHECKSUM_EN is defined, otherwise to START.
REQ-019 The gap counter SHALL clear on each rx_done_tick in LOAD.
REQ-020 If the gap counter reaches TIMEOUT_CYC-1 in LOAD or CHECK, SHALL pulse err=01 and return to IDLE; written memory is not cleared.
REQ-021 START SHALL last exactly one cycle with net_start=1, then go to RUN.
REQ-022 In RUN, on net_done SHALL return to IDLE.
REQ-023 Any rx_done_tick in START or RUN SHALL be dropped with err=11 pulsed; no memory write SHALL occur.
REQ-024 If net_done and rx_done_tick coincide in RUN, SHALL flag the overrun and return to IDLE; that byte is not evaluated as sync.
REQ-025 mem_we SHALL only ever be 1 in LOAD; mem_addr and mem_wdata SHALL be don't-care when mem_we=0.
REQ-026 The counter SHALL never exceed N_PIXELS-1; no address wrap-around is permitted.
REQ-027 Latency: first pixel write in the same cycle as its rx_done_tick; net_start exactly 1 cycle after the final write (no checksum) or after the checksum byte (checksum enabled).

Reset
REQ-028 With reset=1 at a clock edge, SHALL enter IDLE and zero the counter, gap counter and running checksum.
REQ-029 During reset, mem_we=0, net_start=0, err=00 and busy=0.
REQ-030 Reset mid-frame or during RUN SHALL abandon the frame without issuing net_start.

Configuration
REQ-031 Macro UART_IMAGE_LOADER_CHECKSUM_EN: when defined, SHALL keep a running XOR of all pixel bytes and accept one extra byte in CHECK.
REQ-032 With the macro defined and the CHECK byte equal to the running XOR, SHALL go to START; on mismatch, SHALL pulse err=10 and go to IDLE.
REQ-033 With the macro undefined, SHALL omit the CHECK state and the XOR register entirely; the err=10 code SHALL never occur.

Structure
REQ-034 A shared package SHALL hold the state enum, the err code constants and the SYNC_BYTE default.
REQ-035 The gap/timeout counter SHALL be one sub-module, uart_gap_timer (inputs clear and enable; output expire).

Verification
REQ-036 A5, then 784 bytes of value i%256, checksum disabled -> 784 writes at addr 0..783 with data i%256, net_start one cycle after the last write, busy until net_done.
REQ-037 Bytes 00, 3C, then A5 and a full frame -> 00 and 3C ignored with no writes; frame loads normally.
REQ-038 A5 and 100 bytes, then silence of TIMEOUT_CYC cycles -> err=01 pulse, IDLE, no net_start.
REQ-039 Checksum enabled: frame of all 01 bytes (XOR=00) followed by 00 -> net_start; the same frame followed by FF -> err=10, no net_start.
REQ-040 rx_done_tick during RUN, including one coincident with net_done -> err=11, no memory write, back in IDLE after net_done.
REQ-041 reset asserted at pixel 400 -> IDLE next cycle, busy=0, a following full frame loads from addr 0.

Source files
------------

// File: rtl/uart_image_loader_pkg.sv
// Shared types and constants for the UART image loader.
// The CHECK state exists only when UART_IMAGE_LOADER_CHECKSUM_EN is defined.
package uart_image_loader_pkg;

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, CHECK, START, RUN} state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, START, RUN} state_e;
`endif

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_CHECKSUM = 2'b10;
  localparam logic [1:0] ERR_OVERRUN  = 2'b11;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/uart_image_loader_if.sv
// Byte-in / memory-write / inference-handshake bundle for the image loader.
// The master side is the loader; the slave side is the UART, memory and network.
interface uart_image_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_done_tick;
  logic [7:0]        rx_byte;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              net_start;
  logic              net_done;
  logic              busy;
  logic [1:0]        err;

  modport master (
    input  rx_done_tick, rx_byte, net_done,
    output mem_we, mem_addr, mem_wdata, net_start, busy, err
  );

  modport slave (
    output rx_done_tick, rx_byte, net_done,
    input  mem_we, mem_addr, mem_wdata, net_start, busy, err
  );
endinterface

// File: rtl/uart_gap_timer.sv
// Counts idle cycles between received bytes; expire is asserted while the
// count sits at TIMEOUT_CYC-1 and the timer is enabled.
module uart_gap_timer #(
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int            CW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturate at LAST so a stalled enable can never wrap back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clear)                      cnt_d = '0;
    else if (enable && cnt_q != LAST) cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign expire = enable && (cnt_q == LAST);
endmodule

// File: rtl/uart_image_loader.sv
// Loads a SYNC-framed image from a UART byte stream into memory and launches
// inference. Optional trailing XOR check byte: UART_IMAGE_LOADER_CHECKSUM_EN.
module uart_image_loader
  import uart_image_loader_pkg::*;
#(
  parameter int         N_PIXELS    = 784,
  parameter int         ADDR_W      = 10,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYC = 50000
) (
  input logic                  clk,
  input logic                  reset,
  uart_image_loader_if.master  bus
);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(N_PIXELS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        err_q, err_d;
  logic              net_start_q, net_start_d;
  logic              busy_q, busy_d;
  logic              mem_we_c;
  logic              timer_en, timer_clr, expire;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
  assign timer_en = (state_q == LOAD) || (state_q == CHECK);
`else
  assign timer_en = (state_q == LOAD);
`endif

  // Timer only runs inside a frame and restarts on every received byte.
  assign timer_clr = !timer_en || bus.rx_done_tick;

  uart_gap_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_gap (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clr),
    .enable (timer_en),
    .expire (expire)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = ERR_NONE;
    mem_we_c = 1'b0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    csum_d   = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.rx_done_tick && bus.rx_byte == SYNC_BYTE) begin
          state_d = LOAD;
          cnt_d   = '0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      LOAD: begin
        if (bus.rx_done_tick) begin
          mem_we_c = 1'b1;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
          csum_d   = csum_q ^ bus.rx_byte;
`endif
          if (cnt_q == LAST_PIX) begin
            cnt_d = '0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = START;
`endif
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end else if (expire) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = ERR_TIMEOUT;
        end
      end
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
      CHECK: begin
        if (bus.rx_done_tick) begin
          if (bus.rx_byte == csum_q) begin
            state_d = START;
          end else begin
            state_d = IDLE;
            err_d   = ERR_CHECKSUM;
          end
        end else if (expire) begin
          state_d = IDLE;
          err_d   = ERR_TIMEOUT;
        end
      end
`endif
      START: begin
        state_d = RUN;
        if (bus.rx_done_tick) err_d = ERR_OVERRUN;
      end
      RUN: begin
        // A byte coinciding with net_done is still an overrun, never a sync.
        if (bus.rx_done_tick) err_d   = ERR_OVERRUN;
        if (bus.net_done)     state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    net_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      err_q       <= ERR_NONE;
      net_start_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      net_start_q <= net_start_d;
      busy_q      <= busy_d;
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign bus.mem_we    = mem_we_c & ~reset;
  assign bus.mem_addr  = cnt_q;
  assign bus.mem_wdata = bus.rx_byte;
  assign bus.net_start = net_start_q & ~reset;
  assign bus.busy      = busy_q & ~reset;
  assign bus.err       = reset ? ERR_NONE : err_q;
endmodule

// File: tb/tb_uart_image_loader.sv
// Scoreboard bench for uart_image_loader: expected writes / error codes are
// queued by the driver and consumed by a negedge monitor.
module tb_uart_image_loader;
  import uart_image_loader_pkg::*;

  localparam int         ADDR_W = 10;
  localparam int         N_PIX  = 784;
  localparam int         TMO    = 64;
  localparam logic [7:0] SYNC   = 8'hA5;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_image_loader_if #(.ADDR_W(ADDR_W)) bus ();

  uart_image_loader #(
    .N_PIXELS    (N_PIX),
    .ADDR_W      (ADDR_W),
    .SYNC_BYTE   (SYNC),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  wr_t        exp_wr[$];
  logic [1:0] exp_err[$];
  int exp_starts = 0;
  int got_starts = 0;
  int cyc = 0;
  int last_rx_cyc = -100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: sample on the falling edge, well away from the active edge.
  always @(negedge clk) begin
    wr_t        w;
    logic [1:0] e;
    cyc++;
    if (!reset) begin
      if (bus.mem_we === 1'b1) begin
        if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          w = exp_wr.pop_front();
          chk("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
          chk("wr_data", 32'(bus.mem_wdata), 32'(w.data));
        end
      end
      if (bus.net_start === 1'b1) begin
        got_starts++;
        chk("start_latency", 32'(cyc - last_rx_cyc), 32'd1);
      end
      if (bus.err !== ERR_NONE) begin
        if (exp_err.size() == 0) chk("err_unexpected", 32'(bus.err), 32'(ERR_NONE));
        else begin
          e = exp_err.pop_front();
          chk("err_code", 32'(bus.err), 32'(e));
        end
      end
      if (bus.rx_done_tick === 1'b1) last_rx_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.rx_done_tick = 1'b1;
    bus.rx_byte      = b;
    tick();
    bus.rx_done_tick = 1'b0;
    repeat (gap) tick();
  endtask

  function automatic logic [7:0] pix(input int mode, input int i);
    logic [31:0] v;
    case (mode)
      0:       v = 32'(i);
      1:       v = 32'(i * 7 + 3);
      default: v = 32'd1;
    endcase
    return v[7:0];
  endfunction

  // Sends the header and n pixels; queues the writes the DUT must produce.
  task automatic send_pixels(input int mode, input int n, input bit last_gap0);
    logic [7:0] d;
    send_byte(SYNC, 1);
    for (int i = 0; i < n; i++) begin
      d = pix(mode, i);
      exp_wr.push_back('{addr: ADDR_W'(i), data: d});
      send_byte(d, (last_gap0 && i == n - 1) ? 0 : 1);
    end
  endtask

  task automatic send_frame(input int mode, input bit ovr, input bit bad);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < N_PIX; i++) x ^= pix(mode, i);
`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    send_pixels(mode, N_PIX, 1'b0);
    send_byte(bad ? ~x : x, ovr ? 0 : 1);
`else
    send_pixels(mode, N_PIX, ovr);
`endif
    if (bad) exp_err.push_back(ERR_CHECKSUM);
    else     exp_starts++;
    if (ovr) begin
      exp_err.push_back(ERR_OVERRUN);
      send_byte(8'h5A, 1);
    end
  endtask

  task automatic wait_start(input string tag);
    for (int i = 0; i < 20 && got_starts != exp_starts; i++) tick();
    chk(tag, 32'(got_starts), 32'(exp_starts));
  endtask

  task automatic finish_run(input string tag);
    chk({tag, "_busy_run"}, 32'(bus.busy), 32'd1);
    bus.net_done = 1'b1;
    tick();
    bus.net_done = 1'b0;
    tick();
    chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.rx_done_tick = 1'b0;
    bus.rx_byte      = 8'h00;
    bus.net_done     = 1'b0;
    repeat (3) tick();
    chk("rst_mem_we",    32'(bus.mem_we),    32'd0);
    chk("rst_net_start", 32'(bus.net_start), 32'd0);
    chk("rst_err",       32'(bus.err),       32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    reset = 1'b0;
    tick();

    // Ramp frame (contains an in-frame SYNC value as pixel data).
    send_frame(0, 1'b0, 1'b0);
    wait_start("ramp_start");
    finish_run("ramp");

    // Leading junk is ignored, then a normal frame.
    send_byte(8'h00, 2);
    send_byte(8'h3C, 2);
    chk("junk_idle", 32'(bus.busy), 32'd0);
    send_frame(1, 1'b0, 1'b0);
    wait_start("junk_start");
    finish_run("junk");

    // Partial frame followed by silence.
    send_pixels(0, 100, 1'b0);
    exp_err.push_back(ERR_TIMEOUT);
    for (int i = 0; i < TMO + 20 && exp_err.size() != 0; i++) tick();
    chk("timeout_seen", 32'(exp_err.size()), 32'd0);
    chk("timeout_idle", 32'(bus.busy), 32'd0);
    chk("timeout_no_start", 32'(got_starts), 32'(exp_starts));

    // Overruns: in START, in RUN, and coincident with net_done.
    send_frame(0, 1'b1, 1'b0);
    wait_start("ovr_start");
    exp_err.push_back(ERR_OVERRUN);
    send_byte(8'h11, 2);
    chk("ovr_still_run", 32'(bus.busy), 32'd1);
    exp_err.push_back(ERR_OVERRUN);
    bus.net_done     = 1'b1;
    bus.rx_done_tick = 1'b1;
    bus.rx_byte      = SYNC;
    tick();
    bus.net_done     = 1'b0;
    bus.rx_done_tick = 1'b0;
    tick();
    chk("ovr_idle", 32'(bus.busy), 32'd0);
    repeat (3) tick();
    chk("ovr_no_resync", 32'(bus.busy), 32'd0);
    chk("ovr_err_seen", 32'(exp_err.size()), 32'd0);

    // Reset mid-frame, then a full frame must start again from address 0.
    send_pixels(1, 400, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_start", 32'(bus.net_start), 32'd0);
    reset = 1'b0;
    tick();
    chk("midrst_idle", 32'(bus.busy), 32'd0);
    send_frame(0, 1'b0, 1'b0);
    wait_start("midrst_frame_start");
    finish_run("midrst");

`ifdef UART_IMAGE_LOADER_CHECKSUM_EN
    send_frame(2, 1'b0, 1'b0);
    wait_start("csum_good_start");
    finish_run("csum_good");
    send_frame(2, 1'b0, 1'b1);
    repeat (4) tick();
    chk("csum_bad_idle", 32'(bus.busy), 32'd0);
    chk("csum_bad_no_start", 32'(got_starts), 32'(exp_starts));
`endif

    repeat (4) tick();
    chk("final_wr_queue", 32'(exp_wr.size()), 32'd0);
    chk("final_err_queue", 32'(exp_err.size()), 32'd0);
    chk("final_starts", 32'(got_starts), 32'(exp_starts));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
